scarv_cop_palu_seq: RTL and testbench

Issue sequencer for the coprocessor packed ALU. Accepts one decoded instruction at a time from the decode stage, holds its operands stable on the ALU input port until the ALU reports completion (one cycle for most classes, multi-cycle for multiplies), writes the result to the CPR file through an arbitrated write port, then returns a status response to the CPU interface. It sits between decode/operand-read and the packed ALU, and is the ALU's only driver.

---
 rtl/scarv_cop_palu_seq_pkg.sv | 24 ++
 rtl/scarv_cop_palu_seq_if.sv | 71 +++++++
 rtl/scarv_cop_palu_seq_wb.sv | 48 ++++
 rtl/scarv_cop_palu_seq.sv | 174 +++++++++++++++++
 tb/tb_scarv_cop_palu_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scarv_cop_palu_seq_pkg.sv
// Shared definitions for the packed-ALU issue sequencer: FSM encoding,
// response status codes and the pack-width limit.
package scarv_cop_palu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_BAD_PW  = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_status_t;

  localparam logic [2:0] MAX_PW = 3'd4;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/scarv_cop_palu_seq_if.sv
// Bundle of decode, ALU, CPR write and response signals around the sequencer.
// The sequencer takes the slave view; decode/ALU/CPR/CPU side takes master.
interface scarv_cop_palu_seq_if;

  logic        flush;

  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_class;
  logic [4:0]  dec_subclass;
  logic [2:0]  dec_pw;
  logic [31:0] dec_imm;
  logic [3:0]  dec_crd;
  logic [31:0] dec_rs1;
  logic [31:0] dec_rs2;
  logic [31:0] dec_rs3;
  logic [31:0] dec_gpr_rs1;

  logic        palu_ivalid;
  logic        palu_idone;
  logic [3:0]  palu_class;
  logic [4:0]  palu_subclass;
  logic [2:0]  palu_pw;
  logic [31:0] palu_imm;
  logic [31:0] palu_rs1;
  logic [31:0] palu_rs2;
  logic [31:0] palu_rs3;
  logic [31:0] palu_gpr_rs1;
  logic [3:0]  palu_ben;
  logic [31:0] palu_wdata;

  logic        cpr_wreq;
  logic        cpr_wgnt;
  logic [3:0]  cpr_waddr;
  logic [3:0]  cpr_wben;
  logic [31:0] cpr_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_cycles;

  modport slave (
    input  flush,
    input  dec_valid, dec_class, dec_subclass, dec_pw, dec_imm, dec_crd,
           dec_rs1, dec_rs2, dec_rs3, dec_gpr_rs1,
    output dec_ready,
    output palu_ivalid, palu_class, palu_subclass, palu_pw, palu_imm,
           palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1,
    input  palu_idone, palu_ben, palu_wdata,
    output cpr_wreq, cpr_waddr, cpr_wben, cpr_wdata,
    input  cpr_wgnt,
    output rsp_valid, rsp_status, rsp_cycles,
    input  rsp_ready
  );

  modport master (
    output flush,
    output dec_valid, dec_class, dec_subclass, dec_pw, dec_imm, dec_crd,
           dec_rs1, dec_rs2, dec_rs3, dec_gpr_rs1,
    input  dec_ready,
    input  palu_ivalid, palu_class, palu_subclass, palu_pw, palu_imm,
           palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1,
    output palu_idone, palu_ben, palu_wdata,
    input  cpr_wreq, cpr_waddr, cpr_wben, cpr_wdata,
    output cpr_wgnt,
    input  rsp_valid, rsp_status, rsp_cycles,
    output rsp_ready
  );

endinterface

// File: rtl/scarv_cop_palu_seq_wb.sv
// WB stage: holds the ALU result and drives the CPR write request until the
// arbiter grants it or the instruction is flushed.
module scarv_cop_palu_seq_wb (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        i_load,
  input  logic        i_cancel,
  input  logic [3:0]  i_waddr,
  input  logic [3:0]  i_ben,
  input  logic [31:0] i_wdata,
  input  logic        i_gnt,
  output logic        o_wreq,
  output logic [3:0]  o_waddr,
  output logic [3:0]  o_wben,
  output logic [31:0] o_wdata,
  output logic        o_done
);

  logic        r_req;
  logic [3:0]  r_waddr;
  logic [3:0]  r_wben;
  logic [31:0] r_wdata;

  // A grant in the flush cycle still completes the write, so cancel only
  // drops a request that has not been granted.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_req   <= 1'b0;
      r_waddr <= '0;
      r_wben  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_req   <= 1'b1;
      r_waddr <= i_waddr;
      r_wben  <= i_ben;
      r_wdata <= i_wdata;
    end else if (i_cancel || i_gnt) begin
      r_req   <= 1'b0;
    end
  end

  assign o_wreq  = r_req;
  assign o_waddr = r_waddr;
  assign o_wben  = r_wben;
  assign o_wdata = r_wdata;
  assign o_done  = r_req & i_gnt;

endmodule

// File: rtl/scarv_cop_palu_seq.sv
// Issue sequencer for the coprocessor packed ALU: accept, execute with
// timeout, write back to the CPR file, and respond to the CPU.
module scarv_cop_palu_seq
  import scarv_cop_palu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input logic                   g_clk,
  input logic                   g_reset,
  scarv_cop_palu_seq_if.slave   bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_dec_ready;
  logic        r_ivalid;
  logic        r_rsp_valid;
  rsp_status_t r_status;
  logic [7:0]  r_cnt;

  logic [3:0]  r_class;
  logic [4:0]  r_subclass;
  logic [2:0]  r_pw;
  logic [31:0] r_imm;
  logic [3:0]  r_crd;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_rs3;
  logic [31:0] r_gpr_rs1;

  logic w_accept;
  logic w_idone;
  logic w_has_ben;
  logic w_wb_load;
  logic w_timeout;
  logic w_wb_done;

  assign w_accept  = r_dec_ready & bus.dec_valid & ~bus.flush;
  assign w_idone   = (r_state == ST_EXEC) & bus.palu_idone;
  assign w_has_ben = |bus.palu_ben;
  assign w_wb_load = w_idone & w_has_ben & ~bus.flush;
  assign w_timeout = (r_state == ST_EXEC) & ~bus.palu_idone & (r_cnt == TIMEOUT_LAST);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state     <= ST_IDLE;
      r_dec_ready <= 1'b0;
      r_ivalid    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_status    <= RSP_OK;
      r_cnt       <= '0;
    end else if (bus.flush) begin
      r_state     <= ST_IDLE;
      r_dec_ready <= 1'b1;
      r_ivalid    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dec_ready <= 1'b1;
          if (w_accept) begin
            r_dec_ready <= 1'b0;
            r_cnt       <= '0;
            if (bus.dec_pw > MAX_PW) begin
              r_state     <= ST_RSP;
              r_rsp_valid <= 1'b1;
              r_status    <= RSP_BAD_PW;
            end else begin
              r_state  <= ST_EXEC;
              r_ivalid <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          // Counting the leaving cycle too makes rsp_cycles include idone.
          r_cnt <= sat_inc(r_cnt);
          if (w_idone) begin
            r_ivalid <= 1'b0;
            if (w_has_ben) begin
              r_state <= ST_WB;
            end else begin
              r_state     <= ST_RSP;
              r_rsp_valid <= 1'b1;
              r_status    <= RSP_OK;
            end
          end else if (w_timeout) begin
            r_ivalid    <= 1'b0;
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_status    <= RSP_TIMEOUT;
          end
        end
        ST_WB: begin
          if (w_wb_done) begin
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_status    <= RSP_OK;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_dec_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dec_ready <= 1'b1;
          r_ivalid    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operands stay put after completion; they are only loaded on accept.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_class    <= '0;
      r_subclass <= '0;
      r_pw       <= '0;
      r_imm      <= '0;
      r_crd      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs3      <= '0;
      r_gpr_rs1  <= '0;
    end else if (w_accept) begin
      r_class    <= bus.dec_class;
      r_subclass <= bus.dec_subclass;
      r_pw       <= bus.dec_pw;
      r_imm      <= bus.dec_imm;
      r_crd      <= bus.dec_crd;
      r_rs1      <= bus.dec_rs1;
      r_rs2      <= bus.dec_rs2;
      r_rs3      <= bus.dec_rs3;
      r_gpr_rs1  <= bus.dec_gpr_rs1;
    end
  end

  scarv_cop_palu_seq_wb u_wb (
    .g_clk    (g_clk),
    .g_reset  (g_reset),
    .i_load   (w_wb_load),
    .i_cancel (bus.flush),
    .i_waddr  (r_crd),
    .i_ben    (bus.palu_ben),
    .i_wdata  (bus.palu_wdata),
    .i_gnt    (bus.cpr_wgnt),
    .o_wreq   (bus.cpr_wreq),
    .o_waddr  (bus.cpr_waddr),
    .o_wben   (bus.cpr_wben),
    .o_wdata  (bus.cpr_wdata),
    .o_done   (w_wb_done)
  );

  assign bus.dec_ready     = r_dec_ready;
  assign bus.palu_ivalid   = r_ivalid;
  assign bus.palu_class    = r_class;
  assign bus.palu_subclass = r_subclass;
  assign bus.palu_pw       = r_pw;
  assign bus.palu_imm      = r_imm;
  assign bus.palu_rs1      = r_rs1;
  assign bus.palu_rs2      = r_rs2;
  assign bus.palu_rs3      = r_rs3;
  assign bus.palu_gpr_rs1  = r_gpr_rs1;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_status    = r_status;
  assign bus.rsp_cycles    = r_cnt;

endmodule

// File: tb/tb_scarv_cop_palu_seq.sv
// Directed bench for the packed-ALU issue sequencer with a small ALU model
// whose completion latency and result are set per step.
module tb_scarv_cop_palu_seq;

  logic g_clk;
  logic g_reset;

  int tests_run;
  int tests_failed;

  int          alu_delay;   // 0 means the ALU never completes
  logic [3:0]  alu_ben;
  logic [31:0] alu_wdata;
  int          exec_cnt;

  int          wr_count;
  logic [3:0]  wr_addr_last;
  logic [31:0] wr_data_last;

  scarv_cop_palu_seq_if bus ();

  scarv_cop_palu_seq #(.TIMEOUT(8)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) begin
    exec_cnt <= bus.palu_ivalid ? exec_cnt + 1 : 0;
  end

  assign bus.palu_idone = bus.palu_ivalid && (alu_delay != 0) && (exec_cnt == alu_delay - 1);
  assign bus.palu_ben   = alu_ben;
  assign bus.palu_wdata = alu_wdata;

  always @(posedge g_clk) begin
    if (bus.cpr_wreq && bus.cpr_wgnt) begin
      wr_count     <= wr_count + 1;
      wr_addr_last <= bus.cpr_waddr;
      wr_data_last <= bus.cpr_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cls, input logic [2:0] pw, input logic [3:0] crd,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.dec_class = cls;
    bus.dec_pw    = pw;
    bus.dec_crd   = crd;
    bus.dec_rs1   = rs1;
    bus.dec_rs2   = rs2;
    bus.dec_valid = 1'b1;
    tick();
    bus.dec_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    tests_run    = 0;
    tests_failed = 0;
    wr_count     = 0;
    exec_cnt     = 0;
    alu_delay    = 1;
    alu_ben      = 4'h0;
    alu_wdata    = 32'h0;

    g_reset          = 1'b1;
    bus.flush        = 1'b0;
    bus.dec_valid    = 1'b0;
    bus.dec_class    = 4'h0;
    bus.dec_subclass = 5'h0;
    bus.dec_pw       = 3'd0;
    bus.dec_imm      = 32'h0;
    bus.dec_crd      = 4'h0;
    bus.dec_rs1      = 32'h0;
    bus.dec_rs2      = 32'h0;
    bus.dec_rs3      = 32'h0;
    bus.dec_gpr_rs1  = 32'h0;
    bus.cpr_wgnt     = 1'b1;
    bus.rsp_ready    = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_dec_ready",  32'(bus.dec_ready),   32'd0);
    check("rst_ivalid",     32'(bus.palu_ivalid), 32'd0);
    check("rst_wreq",       32'(bus.cpr_wreq),    32'd0);
    check("rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
    check("rst_status",     32'(bus.rsp_status),  32'd0);
    check("rst_cycles",     32'(bus.rsp_cycles),  32'd0);
    check("rst_waddr",      32'(bus.cpr_waddr),   32'd0);
    check("rst_wdata",      bus.cpr_wdata,        32'd0);
    check("rst_palu_rs1",   bus.palu_rs1,         32'd0);
    g_reset = 1'b0;
    tick();
    check("post_rst_dec_ready", 32'(bus.dec_ready), 32'd1);

    // PADD: 1 + 2 into CPR 3, single-cycle
    alu_delay = 1; alu_ben = 4'hF; alu_wdata = 32'h0000_0003;
    issue(4'h1, 3'd0, 4'd3, 32'h0000_0001, 32'h0000_0002);
    check("padd_exec_ivalid", 32'(bus.palu_ivalid), 32'd1);
    check("padd_exec_ready",  32'(bus.dec_ready),   32'd0);
    check("padd_exec_rs1",    bus.palu_rs1,         32'h1);
    check("padd_exec_rs2",    bus.palu_rs2,         32'h2);
    check("padd_exec_class",  32'(bus.palu_class),  32'h1);
    tick();
    check("padd_wb_wreq",   32'(bus.cpr_wreq),    32'd1);
    check("padd_wb_ivalid", 32'(bus.palu_ivalid), 32'd0);
    check("padd_wb_waddr",  32'(bus.cpr_waddr),   32'd3);
    check("padd_wb_wben",   32'(bus.cpr_wben),    32'hF);
    check("padd_wb_wdata",  bus.cpr_wdata,        32'h3);
    tick();
    check("padd_rsp_valid",  32'(bus.rsp_valid),  32'd1);
    check("padd_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("padd_rsp_cycles", 32'(bus.rsp_cycles), 32'd1);
    check("padd_rsp_wreq",   32'(bus.cpr_wreq),   32'd0);
    check("padd_wr_count",   32'(wr_count),       32'd1);
    tick();
    check("padd_idle_ready", 32'(bus.dec_ready), 32'd1);
    check("padd_idle_rsp",   32'(bus.rsp_valid), 32'd0);

    // Illegal pack width
    issue(4'h1, 3'd5, 4'd2, 32'h10, 32'h20);
    check("badpw_ivalid", 32'(bus.palu_ivalid), 32'd0);
    check("badpw_wreq",   32'(bus.cpr_wreq),    32'd0);
    check("badpw_valid",  32'(bus.rsp_valid),   32'd1);
    check("badpw_status", 32'(bus.rsp_status),  32'd1);
    check("badpw_cycles", 32'(bus.rsp_cycles),  32'd0);
    tick();
    check("badpw_idle_ready", 32'(bus.dec_ready), 32'd1);

    // CMOV_F with rs2 != 0: ALU returns ben=0, nothing written
    alu_delay = 1; alu_ben = 4'h0; alu_wdata = 32'h1234_5678;
    issue(4'h2, 3'd0, 4'd5, 32'h1111_1111, 32'h0000_0001);
    check("cmov_ivalid", 32'(bus.palu_ivalid), 32'd1);
    tick();
    check("cmov_wreq",   32'(bus.cpr_wreq),   32'd0);
    check("cmov_valid",  32'(bus.rsp_valid),  32'd1);
    check("cmov_status", 32'(bus.rsp_status), 32'd0);
    check("cmov_cycles", 32'(bus.rsp_cycles), 32'd1);
    check("cmov_wr_count", 32'(wr_count),     32'd1);
    tick();

    // Five-cycle multiply, response held while rsp_ready is low
    alu_delay = 5; alu_ben = 4'h3; alu_wdata = 32'h0000_BEEF;
    bus.rsp_ready = 1'b0;
    issue(4'h3, 3'd1, 4'd9, 32'hA5A5_A5A5, 32'h5A5A_0001);
    for (int i = 0; i < 5; i++) begin
      check("mul_exec_ivalid", 32'(bus.palu_ivalid), 32'd1);
      check("mul_exec_rs1",    bus.palu_rs1,         32'hA5A5_A5A5);
      check("mul_exec_rs2",    bus.palu_rs2,         32'h5A5A_0001);
      tick();
    end
    check("mul_wb_wreq",  32'(bus.cpr_wreq),  32'd1);
    check("mul_wb_waddr", 32'(bus.cpr_waddr), 32'd9);
    check("mul_wb_wben",  32'(bus.cpr_wben),  32'h3);
    check("mul_wb_wdata", bus.cpr_wdata,      32'h0000_BEEF);
    tick();
    check("mul_rsp_valid",  32'(bus.rsp_valid),  32'd1);
    check("mul_rsp_cycles", 32'(bus.rsp_cycles), 32'd5);
    tick();
    check("mul_rsp_hold_valid",  32'(bus.rsp_valid),  32'd1);
    check("mul_rsp_hold_status", 32'(bus.rsp_status), 32'd0);
    check("mul_rsp_hold_cycles", 32'(bus.rsp_cycles), 32'd5);
    check("mul_rsp_hold_ready",  32'(bus.dec_ready),  32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    check("mul_idle_ready", 32'(bus.dec_ready), 32'd1);

    // ALU never completes: timeout after exactly 8 EXEC cycles
    alu_delay = 0; alu_ben = 4'hF; alu_wdata = 32'hFFFF_FFFF;
    wr_before = wr_count;
    issue(4'h3, 3'd2, 4'd1, 32'h7, 32'h8);
    for (int i = 0; i < 8; i++) begin
      check("to_exec_ivalid", 32'(bus.palu_ivalid), 32'd1);
      tick();
    end
    check("to_ivalid_drop", 32'(bus.palu_ivalid), 32'd0);
    check("to_rsp_valid",   32'(bus.rsp_valid),   32'd1);
    check("to_rsp_status",  32'(bus.rsp_status),  32'd2);
    check("to_rsp_cycles",  32'(bus.rsp_cycles),  32'd8);
    check("to_wreq",        32'(bus.cpr_wreq),    32'd0);
    check("to_wr_count",    32'(wr_count),        32'(wr_before));
    tick();
    check("to_idle_ready", 32'(bus.dec_ready), 32'd1);

    // Grant withheld three cycles, then flush together with grant
    alu_delay = 1; alu_ben = 4'hF; alu_wdata = 32'hDEAD_BEEF;
    bus.cpr_wgnt = 1'b0;
    wr_before = wr_count;
    issue(4'h1, 3'd0, 4'd7, 32'h4, 32'h5);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("fl_wb_wreq",     32'(bus.cpr_wreq), 32'd1);
      check("fl_wb_no_write", 32'(wr_count),     32'(wr_before));
      if (i < 2) tick();
    end
    bus.cpr_wgnt = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_write_once", 32'(wr_count),     32'(wr_before + 1));
    check("fl_write_addr", 32'(wr_addr_last), 32'd7);
    check("fl_write_data", wr_data_last,      32'hDEAD_BEEF);
    check("fl_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("fl_dec_ready",  32'(bus.dec_ready), 32'd1);
    check("fl_wreq_clear", 32'(bus.cpr_wreq),  32'd0);
    tick();
    check("fl_no_late_rsp", 32'(bus.rsp_valid), 32'd0);
    check("fl_no_rewrite",  32'(wr_count),      32'(wr_before + 1));

    // Flush beats dec_valid in IDLE
    bus.flush = 1'b1;
    issue(4'h1, 3'd0, 4'd2, 32'h1, 32'h1);
    bus.flush = 1'b0;
    check("flidle_ivalid", 32'(bus.palu_ivalid), 32'd0);
    check("flidle_ready",  32'(bus.dec_ready),   32'd1);
    check("flidle_rsp",    32'(bus.rsp_valid),   32'd0);

    // Reset in the middle of EXEC
    alu_delay = 0;
    wr_before = wr_count;
    issue(4'h3, 3'd0, 4'd4, 32'h9, 32'h9);
    check("mrst_exec_ivalid", 32'(bus.palu_ivalid), 32'd1);
    g_reset = 1'b1;
    tick();
    check("mrst_ivalid", 32'(bus.palu_ivalid), 32'd0);
    check("mrst_ready",  32'(bus.dec_ready),   32'd0);
    check("mrst_rsp",    32'(bus.rsp_valid),   32'd0);
    check("mrst_wreq",   32'(bus.cpr_wreq),    32'd0);
    g_reset = 1'b0;
    tick();
    check("mrst_ready_after", 32'(bus.dec_ready), 32'd1);
    check("mrst_no_write",    32'(wr_count),      32'(wr_before));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
